bit_deserializer: RTL and testbench



---
 rtl/bit_deserializer.sv | 165 ++++++++++++++++
 tb/tb_bit_deserializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer.sv
// Serial-to-parallel framer: hunts for SYNC_WORD, then packs WIDTH-bit words MSB first
// onto a valid/ready output register. Define DESER_PARITY_EN for a trailing even-parity bit per word.
module bit_deserializer #(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   SYNC_WORD = WIDTH'(8'hA5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             resync,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             locked,
  output logic             overflow,
  output logic             parity_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {S_HUNT, S_DATA, S_PAR} state_t;
`else
  typedef enum logic {S_HUNT, S_DATA} state_t;
`endif

  state_t           r_state,    w_state_n;
  logic [WIDTH-1:0] r_window,   w_window_n;
  logic [CW-1:0]    r_fill,     w_fill_n;
  logic [CW-1:0]    r_bitcnt,   w_bitcnt_n;
  logic [WIDTH-1:0] r_asm,      w_asm_n;
  logic [WIDTH-1:0] r_out_data, w_out_data_n;
  logic             r_out_valid, w_out_valid_n;
  logic             r_locked,   w_locked_n;
  logic             r_overflow, w_overflow_n;
  logic             w_done;
  logic [WIDTH-1:0] w_word;
`ifdef DESER_PARITY_EN
  logic             r_parity_err, w_parity_err_n;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_HUNT;
      r_window     <= '0;
      r_fill       <= '0;
      r_bitcnt     <= '0;
      r_asm        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_locked     <= 1'b0;
      r_overflow   <= 1'b0;
`ifdef DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_window     <= w_window_n;
      r_fill       <= w_fill_n;
      r_bitcnt     <= w_bitcnt_n;
      r_asm        <= w_asm_n;
      r_out_data   <= w_out_data_n;
      r_out_valid  <= w_out_valid_n;
      r_locked     <= w_locked_n;
      r_overflow   <= w_overflow_n;
`ifdef DESER_PARITY_EN
      r_parity_err <= w_parity_err_n;
`endif
    end
  end

  // Next-state, framing and output-register logic
  always_comb begin
    w_state_n      = r_state;
    w_window_n     = r_window;
    w_fill_n       = r_fill;
    w_bitcnt_n     = r_bitcnt;
    w_asm_n        = r_asm;
    w_out_data_n   = r_out_data;
    w_out_valid_n  = r_out_valid;
    w_overflow_n   = r_overflow;
    w_done         = 1'b0;
    w_word         = r_asm;
`ifdef DESER_PARITY_EN
    w_parity_err_n = r_parity_err;
`endif

    if (resync) begin
      // Bit sampled alongside resync is dropped; the output word may still drain
      w_state_n      = S_HUNT;
      w_window_n     = '0;
      w_fill_n       = '0;
      w_bitcnt_n     = '0;
      w_overflow_n   = 1'b0;
`ifdef DESER_PARITY_EN
      w_parity_err_n = 1'b0;
`endif
    end else if (bit_valid) begin
      unique case (r_state)
        S_HUNT: begin
          w_window_n = {r_window[WIDTH-2:0], bit_in};
          w_fill_n   = (r_fill == CW'(WIDTH)) ? r_fill : r_fill + CW'(1);
          if ((w_fill_n == CW'(WIDTH)) && (w_window_n == SYNC_WORD)) begin
            w_state_n  = S_DATA;
            w_bitcnt_n = '0;
          end
        end
        S_DATA: begin
          w_asm_n = {r_asm[WIDTH-2:0], bit_in};
          if (r_bitcnt == CW'(WIDTH - 1)) begin
            w_bitcnt_n = '0;
`ifdef DESER_PARITY_EN
            w_state_n  = S_PAR;
`else
            w_done     = 1'b1;
            w_word     = w_asm_n;
`endif
          end else begin
            w_bitcnt_n = r_bitcnt + CW'(1);
          end
        end
`ifdef DESER_PARITY_EN
        S_PAR: begin
          if (^{r_asm, bit_in} == 1'b0) begin
            w_done = 1'b1;
            w_word = r_asm;
          end else begin
            w_parity_err_n = 1'b1;
          end
          w_state_n = S_DATA;
        end
`endif
        default: w_state_n = S_HUNT;
      endcase
    end

    if (r_out_valid && out_ready) begin
      w_out_valid_n = 1'b0;
    end
    // A completing word is loaded if the register is empty or draining this edge
    if (w_done) begin
      if (!r_out_valid || out_ready) begin
        w_out_data_n  = w_word;
        w_out_valid_n = 1'b1;
      end else begin
        w_overflow_n  = 1'b1;
      end
    end

    w_locked_n = (w_state_n != S_HUNT);
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign locked    = r_locked;
  assign overflow  = r_overflow;
`ifdef DESER_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bit_deserializer;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] SYNC = 8'hA5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         resync = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         locked;
  logic         overflow;
  logic         parity_err;

  int total = 0;
  int bad   = 0;

  bit_deserializer #(.WIDTH(W), .SYNC_WORD(SYNC)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .resync(resync), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .locked(locked), .overflow(overflow),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bit queues for the hunt window and the word being collected
  bit           m_hq[$];
  bit           m_dq[$];
  logic         m_locked;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovf;
  logic         m_perr;
  logic         md_done;
  logic [W-1:0] md_word;
  int           md_ones;

  function automatic logic [W-1:0] pack_h();
    logic [W-1:0] v = '0;
    foreach (m_hq[i]) v = {v[W-2:0], m_hq[i]};
    return v;
  endfunction

  function automatic logic [W-1:0] pack_d();
    logic [W-1:0] v = '0;
    foreach (m_dq[i]) v = {v[W-2:0], m_dq[i]};
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hq.delete(); m_dq.delete();
      m_locked = 1'b0; m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    end else begin
      md_done = 1'b0;
      md_word = '0;
      if (resync) begin
        m_hq.delete(); m_dq.delete();
        m_locked = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
      end else if (bit_valid) begin
        if (!m_locked) begin
          m_hq.push_back(bit_in);
          if (m_hq.size() > W) void'(m_hq.pop_front());
          if (m_hq.size() == W && pack_h() == SYNC) begin
            m_locked = 1'b1;
            m_hq.delete(); m_dq.delete();
          end
        end else if (m_dq.size() < W) begin
          m_dq.push_back(bit_in);
`ifndef DESER_PARITY_EN
          if (m_dq.size() == W) begin
            md_done = 1'b1; md_word = pack_d(); m_dq.delete();
          end
`endif
        end else begin
          md_ones = $countones(pack_d()) + int'(bit_in);
          if (md_ones % 2 == 0) begin
            md_done = 1'b1; md_word = pack_d();
          end else begin
            m_perr = 1'b1;
          end
          m_dq.delete();
        end
      end
      if (md_done) begin
        if (!m_valid || out_ready) begin
          m_data = md_word; m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) chk("mdl_out_data", 32'(out_data), 32'(m_data));
    chk("mdl_locked", 32'(locked), 32'(m_locked));
    chk("mdl_overflow", 32'(overflow), 32'(m_ovf));
    chk("mdl_parity_err", 32'(parity_err), 32'(m_perr));
  end

  task automatic step(input logic v, input logic b, input logic rdy, input logic rs);
    bit_valid = v; bit_in = b; out_ready = rdy; resync = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic send_sync();
    logic [W-1:0] s = SYNC;
    for (int i = W - 1; i >= 0; i--) step(1'b1, s[i], 1'b1, 1'b0);
  endtask

  // rdy applies to all bits except the word's final one (parity bit when enabled)
  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic rdy_last);
`ifdef DESER_PARITY_EN
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], rdy, 1'b0);
    step(1'b1, ^w, rdy_last, 1'b0);
`else
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], (i == 0) ? rdy_last : rdy, 1'b0);
`endif
  endtask

  initial begin
    logic [W-1:0] g;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    rst = 1'b0;

    // Lock after leading junk (overlap), then capture 0x3C
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send_sync();
    chk("lock_after_sync", 32'(locked), 32'd1);
    send_word(8'h3C, 1'b1, 1'b1);
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_data", 32'(out_data), 32'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("cap_valid_one_cycle", 32'(out_valid), 32'd0);

    // Back-pressure: second word is dropped and overflow sticks
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send_sync();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    chk("bp_data_held", 32'(out_data), 32'h11);
    chk("bp_overflow", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Word completes on the same edge the held word is accepted
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resync_clears_ovf", 32'(overflow), 32'd0);
    send_sync();
    send_word(8'h5A, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b1);
    chk("sim_valid", 32'(out_valid), 32'd1);
    chk("sim_data", 32'(out_data), 32'hC3);
    chk("sim_no_ovf", 32'(overflow), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Gaps inside a word
    g = 8'hF0;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, g[i], 1'b1, 1'b0);
      if (i != 0) step(1'b0, 1'b1, 1'b1, 1'b0);
    end
`ifdef DESER_PARITY_EN
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, ^g, 1'b1, 1'b0);
`endif
    chk("gap_data", 32'(out_data), 32'hF0);
    chk("gap_valid", 32'(out_valid), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("resync_unlock", 32'(locked), 32'd0);
    send_word(8'h0F, 1'b1, 1'b1);
    chk("unlocked_no_word", 32'(out_valid), 32'd0);

    // Async reset mid-word
    send_sync();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_no_word", 32'(out_valid), 32'd0);

    // Back-to-back words; sync pattern inside data is plain data
    send_sync();
    send_word(8'h00, 1'b1, 1'b1);
    send_word(8'hFF, 1'b1, 1'b1);
    send_word(8'hA5, 1'b1, 1'b1);
    chk("sync_as_data", 32'(out_data), 32'hA5);
    chk("still_locked", 32'(locked), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DESER_PARITY_EN
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send_sync();
    for (int i = W - 1; i >= 0; i--) begin
      g = 8'h03;
      step(1'b1, g[i], 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("par_ok_valid", 32'(out_valid), 32'd1);
    chk("par_ok_data", 32'(out_data), 32'h03);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      g = 8'h07;
      step(1'b1, g[i], 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("par_bad_no_valid", 32'(out_valid), 32'd0);
    chk("par_err_set", 32'(parity_err), 32'd1);
`else
    chk("parity_tied_low", 32'(parity_err), 32'd0);
`endif

    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
